// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/RAM bus bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int unsigned WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic [WORD_W-1:0] iload;
    logic              iwait;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic [WORD_W-1:0] dload;
    logic              dwait;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the shared RAM port with starvation guard
// Optional performance counters enabled by MEM_ARBITER_PERF_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned WORD_W       = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0]   icount,
    output logic [31:0]   dcount,
    output logic [31:0]   stallcount
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] I_GNT = 2'd1;
    localparam logic [1:0] D_GNT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    localparam logic [3:0]        LIMIT  = STARVE_LIMIT[3:0];
    localparam logic [WORD_W-1:0] ZERO_W = '0;

    logic [1:0] state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       d_req;
    logic       force_i;
    logic       access;
    logic       i_done;
    logic       d_done;

    assign d_req   = bus.dREN | bus.dWEN;
    assign force_i = (starve_q == LIMIT) & bus.iREN;
    assign access  = (bus.ramstate == RAM_ACCESS);
    assign i_done  = (state_q == I_GNT) & access;
    assign d_done  = (state_q == D_GNT) & access;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req && !force_i) begin
                    state_d = D_GNT;
                end else if (bus.iREN) begin
                    state_d = I_GNT;
                end
            end
            I_GNT:   if (access || !bus.iREN) state_d = IDLE;
            D_GNT:   if (access || !d_req)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counts data grants that jumped ahead of a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (!bus.iREN) begin
            starve_d = 4'd0;
        end else if (state_q == IDLE && state_d == I_GNT) begin
            starve_d = 4'd0;
        end else if (state_q == IDLE && state_d == D_GNT && starve_q < LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // RAM side decodes straight from registered state so reset clears it at once.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = ZERO_W;
        bus.ramstore = ZERO_W;
        case (state_q)
            I_GNT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
            end
            D_GNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramWEN   = bus.dWEN;
                bus.ramstore = bus.dstore;
            end
            default: ;
        endcase
    end

    assign bus.iwait = ~i_done;
    assign bus.dwait = ~d_done;
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] icount_q, dcount_q, stall_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount_q <= 32'd0;
            dcount_q <= 32'd0;
            stall_q  <= 32'd0;
        end else begin
            if (i_done)                 icount_q <= icount_q + 32'd1;
            if (d_done)                 dcount_q <= dcount_q + 32'd1;
            if (bus.iREN && bus.iwait)  stall_q  <= stall_q + 32'd1;
        end
    end

    assign icount     = icount_q;
    assign dcount     = dcount_q;
    assign stallcount = stall_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-programmable RAM model
module tb_mem_arbiter;
    localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic CLK;
    logic nRST;
    mem_arbiter_if bus ();

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] icount, dcount, stallcount;
    int          stall_model;
`endif

    mem_arbiter #(.STARVE_LIMIT(4), .WORD_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef MEM_ARBITER_PERF_EN
        ,
        .icount     (icount),
        .dcount     (dcount),
        .stallcount (stallcount)
`endif
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   i_done   = 0;
    int   d_done   = 0;
    int   ram_lat  = 0;
    bit   ram_err  = 0;
    logic [3:0]  starve_at_icomp;
    txn_t iq[$];
    txn_t dq[$];
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    initial begin
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
        end
    end

    // RAM model: ACCESS after ram_lat BUSY cycles of continuous enable.
    initial begin
        int  cnt;
        logic en;
        cnt = 0;
        bus.ramstate = R_FREE;
        bus.ramload  = 32'd0;
        forever begin
            @(posedge CLK);
            #2;
            en = bus.ramREN | bus.ramWEN;
            cnt = (nRST && en) ? cnt + 1 : 0;
            if (ram_err)              bus.ramstate = R_ERROR;
            else if (en && cnt > ram_lat) bus.ramstate = R_ACCESS;
            else if (en)              bus.ramstate = R_BUSY;
            else                      bus.ramstate = R_FREE;
            if (bus.ramstate == R_ACCESS && bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
            bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr] : dflt(bus.ramaddr);
        end
    end

    // Completion monitor: pops the scoreboard on each wait=0 cycle.
    initial begin
        txn_t e;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
`ifdef MEM_ARBITER_PERF_EN
                stall_model = 0;
`endif
            end else begin
`ifdef MEM_ARBITER_PERF_EN
                if (bus.iREN && bus.iwait) stall_model++;
`endif
                if (!bus.iwait && !bus.dwait) chk_eq("both_wait_low", {30'd0, bus.iwait, bus.dwait}, 32'd3);
                if (!bus.iwait) begin
                    if (iq.size() == 0) begin
                        chk_eq("i_unexpected", iq.size(), 1);
                    end else begin
                        e = iq.pop_front();
                        chk_eq("i_addr", bus.ramaddr, e.addr);
                        chk_eq("i_data", bus.iload, e.data);
                        starve_at_icomp = dut.starve_q;
                        i_done++;
                    end
                end
                if (!bus.dwait) begin
                    if (dq.size() == 0) begin
                        chk_eq("d_unexpected", dq.size(), 1);
                    end else begin
                        e = dq.pop_front();
                        chk_eq("d_addr", bus.ramaddr, e.addr);
                        chk_eq("d_wen", {31'd0, bus.ramWEN}, {31'd0, e.wr});
                        if (e.wr) chk_eq("d_store", bus.ramstore, e.data);
                        else      chk_eq("d_load", bus.dload, e.data);
                        d_done++;
                    end
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, output int lat);
        txn_t e;
        int   start;
        bit   done;
        e.wr = 1'b0; e.addr = a; e.data = ref_rd(a);
        iq.push_back(e);
        start = cyc;
        done  = 0;
        bus.iaddr = a;
        bus.iREN  = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (!bus.iwait) begin done = 1; break; end
        end
        chk_eq("i_timeout", {31'd0, done}, 32'd1);
        lat = cyc - start;
        @(posedge CLK); #1;
        bus.iREN = 1'b0;
    endtask

    task automatic do_data(input bit wr, input logic [31:0] a, input logic [31:0] d, output int lat);
        txn_t e;
        int   start;
        bit   done;
        e.wr = wr; e.addr = a; e.data = wr ? d : ref_rd(a);
        if (wr) ref_mem[a] = d;
        dq.push_back(e);
        start = cyc;
        done  = 0;
        bus.daddr  = a;
        bus.dstore = d;
        bus.dWEN   = wr;
        bus.dREN   = ~wr;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (!bus.dwait) begin done = 1; break; end
        end
        chk_eq("d_timeout", {31'd0, done}, 32'd1);
        lat = cyc - start;
        @(posedge CLK); #1;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat_i, lat_d, d_base, ci, cd;
        logic [31:0] wd [6];
        bit ok;
        nRST = 1'b0;
        bus.iREN = 1'b0; bus.iaddr = 32'd0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'd0; bus.dstore = 32'd0;
        ram_mem[32'h40] = 32'h2402_0005;
        ref_mem[32'h40] = 32'h2402_0005;
        repeat (2) @(negedge CLK);
        chk_eq("rst_ramREN",  {31'd0, bus.ramREN}, 32'd0);
        chk_eq("rst_ramWEN",  {31'd0, bus.ramWEN}, 32'd0);
        chk_eq("rst_ramaddr", bus.ramaddr, 32'd0);
        chk_eq("rst_ramstore", bus.ramstore, 32'd0);
        chk_eq("rst_waits",   {30'd0, bus.iwait, bus.dwait}, 32'd3);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        chk_eq("post_rst_state", {30'd0, dut.state_q}, 32'd0);

        ram_lat = 2;
        do_fetch(32'h40, lat);
        chk_eq("fetch_lat2", lat, 3);
        chk_eq("fetch_after_ren", {31'd0, bus.ramREN}, 32'd0);
        chk_eq("fetch_after_iwait", {31'd0, bus.iwait}, 32'd1);

        ram_lat = 0;
        do_fetch(32'h44, lat);
        chk_eq("fetch_lat_min", lat, 1);

        fork
            begin do_data(1'b0, 32'h100, 32'd0, lat_d); cd = cyc; end
            begin do_fetch(32'h48, lat_i); ci = cyc; end
        join
        chk_eq("cont_d_lat", lat_d, 1);
        chk_eq("cont_i_lat", lat_i, 3);
        chk_eq("cont_gap", ci - cd, 2);

        d_base = d_done;
        fork
            begin
                int la;
                for (int w = 0; w < 6; w++) do_data(1'b1, 32'h400 + w * 4, $urandom, la);
            end
            begin
                int lf;
                do_fetch(32'h80, lf);
                chk_eq("starve_writes", d_done - d_base, 4);
                chk_eq("starve_cleared", {28'd0, starve_at_icomp}, 32'd0);
            end
        join

        ram_err = 1'b1;
        bus.daddr = 32'h200; bus.dREN = 1'b1;
        @(posedge CLK); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk_eq("err_dwait", {31'd0, bus.dwait}, 32'd1);
            chk_eq("err_ren", {31'd0, bus.ramREN}, 32'd1);
            @(posedge CLK); #1;
        end
        bus.dREN = 1'b0;
        @(negedge CLK);
        chk_eq("err_drop_dwait", {31'd0, bus.dwait}, 32'd1);
        @(posedge CLK); #1;
        chk_eq("err_drop_idle", {30'd0, dut.state_q}, 32'd0);
        ram_err = 1'b0;
        @(posedge CLK); #1;

        for (int w = 0; w < 6; w++) begin
            wd[w] = $urandom;
            ram_lat = $urandom_range(0, 3);
            do_data(1'b1, 32'h300 + w * 4, wd[w], lat);
            chk_eq("rw_wr_lat", lat, ram_lat + 1);
        end
        for (int w = 0; w < 6; w++) begin
            ram_lat = $urandom_range(0, 3);
            do_data(1'b0, 32'h300 + w * 4, 32'd0, lat);
            chk_eq("rw_rd_lat", lat, ram_lat + 1);
        end

        ram_lat = 10;
        bus.daddr = 32'h500; bus.dstore = 32'h1234_5678; bus.dWEN = 1'b1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (bus.ramWEN) begin ok = 1; break; end
        end
        chk_eq("rmid_wen_seen", {31'd0, ok}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk_eq("rmid_wen", {31'd0, bus.ramWEN}, 32'd0);
        chk_eq("rmid_waits", {30'd0, bus.iwait, bus.dwait}, 32'd3);
        chk_eq("rmid_addr", bus.ramaddr, 32'd0);
        bus.dWEN = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        chk_eq("rmid_idle", {30'd0, dut.state_q}, 32'd0);
        chk_eq("rmid_starve", {28'd0, dut.starve_q}, 32'd0);

`ifdef MEM_ARBITER_PERF_EN
        ram_lat = 0;
        do_fetch(32'h40, lat);
        do_data(1'b0, 32'h300, 32'd0, lat);
        do_fetch(32'h44, lat);
        do_data(1'b0, 32'h304, 32'd0, lat);
        do_fetch(32'h48, lat);
        repeat (2) @(posedge CLK);
        #1;
        chk_eq("perf_icount", icount, 32'd3);
        chk_eq("perf_dcount", dcount, 32'd2);
        chk_eq("perf_stall", stallcount, stall_model);
`endif

        chk_eq("iq_empty", iq.size(), 0);
        chk_eq("dq_empty", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester and the data requester.
- Data requests are driven by the control unit's dREN/dWEN.
- Registered grant FSM; data side has priority; a starvation counter guarantees fetch progress.
- Sits between the caches/request unit and the RAM model.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits, before fetch is forced; legal 1..15.
- WORD_W, 32: address/data width (word_t).

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction fetch request
- iaddr  input  32  fetch address
- iload  output  32  fetch data (ramload passthrough)
- iwait  output  1  fetch not complete
- dREN  input  1  data read request
- dWEN  input  1  data write request (dREN&dWEN illegal; dWEN wins)
- daddr  input  32  data address
- dstore  input  32  store data
- dload  output  32  load data (ramload passthrough)
- dwait  output  1  data access not complete
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3 (ramstate_t)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (anytime, including mid-access): state=IDLE, starve_cnt=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
- States:
  - IDLE: RAM enables 0. Next state chosen from current requests:
    - if (dREN|dWEN) and not force_i -> D_GNT;
    - else if iREN -> I_GNT;
    - else stay in IDLE.
  - force_i = (starve_cnt == STARVE_LIMIT) & iREN.
  - I_GNT: ramREN=1, ramaddr=iaddr.
    - ramstate==ACCESS: iwait=0 this cycle, iload=ramload, next IDLE.
    - iREN drops: next IDLE, no completion.
  - D_GNT: ramaddr=daddr, ramREN=dREN&~dWEN, ramWEN=dWEN, ramstore=dstore.
    - ramstate==ACCESS: dwait=0, dload=ramload, next IDLE.
    - dREN|dWEN drops: next IDLE.
- Waits: iwait=~(state==I_GNT & ramstate==ACCESS); dwait=~(state==D_GNT & ramstate==ACCESS). Combinational from registered state. Never both 0 in one cycle.
- Latency: minimum 2 cycles request->completion (1 arbitration cycle in IDLE + ≥1 granted cycle). Back-to-back grants are separated by one IDLE cycle.
- ramstate BUSY/FREE/ERROR while granted: hold grant and outputs unchanged; ERROR is retried indefinitely and never completes.
- Grant is held until completion or request withdrawal; no preemption.
- Address/data change while granted: passed through combinationally.
- starve_cnt (4 bits, saturating at STARVE_LIMIT):
  - +1 on each IDLE->D_GNT transition while iREN=1;
  - cleared on IDLE->I_GNT, or any cycle iREN=0;
  - not incremented past limit.
- Simultaneous iREN and dREN in IDLE with starve_cnt<STARVE_LIMIT: data wins.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- Defined: adds outputs icount[31:0], dcount[31:0], stallcount[31:0].
  - icount/dcount: +1 per completed fetch/data access.
  - stallcount: +1 each cycle iREN=1 & iwait=1.
  - All reset to 0 asynchronously; wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset mid-access: assert nRST=0 during D_GNT with ramWEN=1 -> ramWEN drops immediately (same cycle, async), iwait=dwait=1; after release, state IDLE.
- Single fetch: iREN=1, iaddr=0x0000_0040, RAM returns ACCESS after 2 BUSY cycles with ramload=0x2402_0005 -> ramREN=1 from cycle 1, iwait=0 and iload=0x2402_0005 in cycle 3, then ramREN=0.
- Contention: iREN=dREN=1 together, daddr=0x100 -> D_GNT first (ramaddr=0x100), I_GNT after dwait=0 plus one IDLE cycle.
- Starvation: iREN held, dWEN re-asserted after every completion, STARVE_LIMIT=4 -> exactly 4 data writes, then fetch granted, starve_cnt returns to 0.
- Withdrawal/error: ramstate=ERROR for 5 cycles in D_GNT -> dwait stays 1, grant held; deassert dREN -> IDLE next cycle, no dwait=0 pulse.
- With MEM_ARBITER_PERF_EN: 3 fetches + 2 loads at 1-cycle ACCESS -> icount=3, dcount=2; stallcount equals the number of cycles iREN=1 & iwait=1.
